dmem_arbiter: RTL and testbench

Sequences the single-port data memory and shares it between two requesters: the pipeline MEM stage (CPU port) and a debug/loader master (DBG port). The arbiter owns all memory control signals. It stalls the pipeline while a CPU access is pending or while the memory is busy with a debug access. Arbitration uses CPU priority with a starvation bound for DBG.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 95 +++++++++
 tb/tb_dmem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Signal bundle shared by the data-memory arbiter, its CPU and debug requesters
// and the single-port data memory. The arbiter uses the slave view.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and a debug
// master: CPU priority, with DBG forced through after DBG_MAX_WAIT lost contests.
module dmem_arbiter #(
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);
  localparam logic [3:0] WAIT_MAX = 4'(DBG_MAX_WAIT);

  state_t     state;
  owner_t     owner;
  logic [3:0] starve_cnt;
  logic [3:0] lat_cnt;

  logic       any_req;
  logic       dbg_wins;
  logic [3:0] starve_nxt;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    any_req    = bus.cpu_req | bus.dbg_req;
    dbg_wins   = bus.dbg_req & (~bus.cpu_req | (starve_cnt == WAIT_MAX));
    starve_nxt = starve_cnt;
    // A lone CPU request leaves the count alone; any DBG request either clears it or adds a lost contest.
    if (bus.dbg_req) begin
      starve_nxt = dbg_wins ? 4'd0 : starve_cnt + 4'd1;
    end
  end

  assign bus.dbg_gnt    = reset & (state == IDLE) & dbg_wins;
  assign bus.cpu_stall  = reset & bus.cpu_req & ~((state == DONE) & (owner == OWN_CPU));
  assign bus.dbg_rvalid = (state == DONE) & (owner == OWN_DBG);
  assign bus.busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= OWN_CPU;
      starve_cnt    <= '0;
      lat_cnt       <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
    end else begin
      // NOTE: sequential state uses <= so every branch reads the values from before this edge.
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state      <= BUSY;
            owner      <= dbg_wins ? OWN_DBG : OWN_CPU;
            starve_cnt <= starve_nxt;
            lat_cnt    <= LAT_INIT;
            bus.mem_en <= 1'b1;
            if (dbg_wins) begin
              bus.mem_we    <= bus.dbg_we;
              bus.mem_addr  <= bus.dbg_addr;
              bus.mem_wdata <= bus.dbg_wdata;
            end else begin
              bus.mem_we    <= bus.cpu_we;
              bus.mem_addr  <= bus.cpu_addr;
              bus.mem_wdata <= bus.cpu_wdata;
            end
          end
        end
        BUSY: begin
          bus.mem_en <= 1'b0;
          // mem_we still holds the issued access type, so it doubles as the latched write flag.
          if (lat_cnt == 4'd0) begin
            state <= DONE;
            if (!bus.mem_we) begin
              if (owner == OWN_DBG) bus.dbg_rdata <= bus.mem_rdata;
              else                  bus.cpu_rdata <= bus.mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked against
// a cycle-arithmetic transaction model of the arbiter.
module tb_dmem_arbiter;

  localparam int LAT  = 2;
  localparam int MAXW = 4;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter_if bus1 ();

  dmem_arbiter #(.MEM_LAT(LAT), .DBG_MAX_WAIT(MAXW)) u_dut (
    .clk(clk), .reset(reset), .bus(bus));
  dmem_arbiter #(.MEM_LAT(LAT1), .DBG_MAX_WAIT(3)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int total = 0;
  int bad   = 0;

  // Memory models: main one stores words, the second returns addr^key. Both drive
  // junk outside the single valid cycle so early or late capture is visible.
  logic [31:0] phys_mem [64];
  logic [31:0] ref_mem  [64];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;
  int unsigned since_en, since_en1;

  always @(posedge clk) begin
    if (pre_we) phys_mem[pre_idx] <= pre_val;
    else if (bus.mem_en && bus.mem_we) phys_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    if (!reset) begin
      since_en  <= 0;
      since_en1 <= 0;
    end else begin
      if (bus.mem_en) since_en <= 1;
      else if (since_en != 0 && since_en < 20) since_en <= since_en + 1;
      if (bus1.mem_en) since_en1 <= 1;
      else if (since_en1 != 0 && since_en1 < 20) since_en1 <= since_en1 + 1;
    end
  end

  assign bus.mem_rdata  = (since_en == LAT) ? phys_mem[bus.mem_addr[7:2]] : 32'hBADD_A7A0;
  assign bus1.mem_rdata = (since_en1 == LAT1) ? (bus1.mem_addr ^ 32'h5A5A_0000) : 32'hBADD_A7A1;

  // Expected contents of the two read-data registers.
  logic [31:0] m_cpu, m_dbg;

  function automatic logic [4:0] st0();
    return {bus.cpu_stall, bus.dbg_gnt, bus.dbg_rvalid, bus.busy, bus.mem_en};
  endfunction

  function automatic logic [4:0] st1();
    return {bus1.cpu_stall, bus1.dbg_gnt, bus1.dbg_rvalid, bus1.busy, bus1.mem_en};
  endfunction

  function automatic logic [31:0] rnd_addr();
    return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.cpu_req = 1'b1;  bus.dbg_req = 1'b1;
    bus1.cpu_req = 1'b1; bus1.dbg_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] idx;
      idx = 6'(i);
      @(posedge clk); #1;
      pre_we  = 1'b1;
      pre_idx = idx;
      pre_val = (i == 4) ? 32'hDEAD_BEEF : (i == 16) ? 32'hCAFE_F00D : $urandom();
      ref_mem[idx] = pre_val;
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
    @(negedge clk);
    total++;
    if (st0() !== 5'b0) begin
      bad++; $display("FAIL reset_status got=%b want=00000", st0());
    end
    total++;
    if (st1() !== 5'b0) begin
      bad++; $display("FAIL reset_status1 got=%b want=00000", st1());
    end
    total++;
    if ({bus.cpu_rdata, bus.dbg_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", bus.cpu_rdata, bus.dbg_rdata);
    end
    total++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 65'h0) begin
      bad++; $display("FAIL reset_membus got we=%b a=%h d=%h want 0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;  bus.dbg_req = 1'b0;
    bus1.cpu_req = 1'b0; bus1.dbg_req = 1'b0;
    reset = 1'b1;
    m_cpu = '0;
    m_dbg = '0;
  endtask

  // One access on an idle arbiter; cycle 0 is the issue cycle.
  task automatic run_access(input string name, input bit is_dbg, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [4:0] exp;
    @(posedge clk); #1;
    if (is_dbg) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
    if (we) ref_mem[addr[7:2]] = wdata;
    else if (is_dbg) m_dbg = ref_mem[addr[7:2]];
    else m_cpu = ref_mem[addr[7:2]];
    for (int c = 0; c <= LAT + 3; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (is_dbg && c == 1) bus.dbg_req = 1'b0;
        if (!is_dbg && c == LAT + 3) bus.cpu_req = 1'b0;
      end
      @(negedge clk);
      exp = {!is_dbg && c <= LAT + 1, is_dbg && c == 0, is_dbg && c == LAT + 2,
             c >= 1 && c <= LAT + 2, c == 1};
      total++;
      if (st0() !== exp) begin
        bad++; $display("FAIL %s status c=%0d got=%b want=%b", name, c, st0(), exp);
      end
      if (c == 1) begin
        total++;
        if (bus.mem_we !== we || bus.mem_addr !== addr || (we && bus.mem_wdata !== wdata)) begin
          bad++; $display("FAIL %s membus got we=%b a=%h d=%h want we=%b a=%h d=%h",
                          name, bus.mem_we, bus.mem_addr, bus.mem_wdata, we, addr, wdata);
        end
      end
      if (c == LAT + 2) begin
        total++;
        if (bus.cpu_rdata !== m_cpu || bus.dbg_rdata !== m_dbg) begin
          bad++; $display("FAIL %s rdata got=%h/%h want=%h/%h", name,
                          bus.cpu_rdata, bus.dbg_rdata, m_cpu, m_dbg);
        end
      end
    end
  endtask

  task automatic test_cpu_read();  run_access("cpu_rd", 1'b0, 1'b0, 32'h10, 32'h0);         endtask
  task automatic test_cpu_write(); run_access("cpu_wr", 1'b0, 1'b1, 32'h20, 32'h1234_5678); endtask
  task automatic test_dbg_read();  run_access("dbg_rd", 1'b1, 1'b0, 32'h40, 32'h0);         endtask

  // Both requesters held high; every access lasts LAT+3 cycles back to back.
  task automatic test_contention();
    int cnt = 0;
    bit cur_dbg = 1'b0;
    bit prev_cpu = 1'b1;
    logic [4:0] exp;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = rnd_addr();
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < LAT + 3; c++) begin
        if (!(k == 0 && c == 0)) begin @(posedge clk); #1; end
        if (c == 0 && prev_cpu) bus.cpu_addr = rnd_addr();
        if (c == 1 && cur_dbg) bus.dbg_addr = rnd_addr();
        if (c == 0) begin
          cur_dbg = (cnt == MAXW);
          cnt = cur_dbg ? 0 : cnt + 1;
          if (cur_dbg) m_dbg = ref_mem[bus.dbg_addr[7:2]];
          else m_cpu = ref_mem[bus.cpu_addr[7:2]];
        end
        @(negedge clk);
        exp = {!(!cur_dbg && c == LAT + 2), cur_dbg && c == 0, cur_dbg && c == LAT + 2, c >= 1, c == 1};
        total++;
        if (st0() !== exp) begin
          bad++; $display("FAIL contend k=%0d c=%0d got=%b want=%b", k, c, st0(), exp);
        end
        if (c == LAT + 2) begin
          total++;
          if (bus.cpu_rdata !== m_cpu || bus.dbg_rdata !== m_dbg) begin
            bad++; $display("FAIL contend_rdata k=%0d got=%h/%h want=%h/%h", k,
                            bus.cpu_rdata, bus.dbg_rdata, m_cpu, m_dbg);
          end
        end
      end
      prev_cpu = !cur_dbg;
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);
    total++;
    if (st0() !== 5'b0) begin
      bad++; $display("FAIL contend_idle got=%b want=00000", st0());
    end
  endtask

  task automatic test_reset_midaccess();
    @(posedge clk); #1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h40;
    @(negedge clk);
    total++;
    if (st0() !== 5'b01000) begin
      bad++; $display("FAIL rstmid_gnt got=%b want=01000", st0());
    end
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++;
    if (st0() !== 5'b0) begin
      bad++; $display("FAIL rstmid_abort got=%b want=00000", st0());
    end
    m_cpu = '0;
    m_dbg = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (st0() !== 5'b0 || bus.dbg_rdata !== 32'h0) begin
        bad++; $display("FAIL rstmid_after c=%0d got=%b rd=%h want=00000 rd=0", c, st0(), bus.dbg_rdata);
      end
    end
    run_access("post_rst_cpu", 1'b0, 1'b0, rnd_addr(), 32'h0);
    run_access("post_rst_dbg", 1'b1, 1'b1, rnd_addr(), $urandom());
  endtask

  task automatic test_back_to_back();
    int hi = 0;
    int n_done = 0;
    bit prev_en = 1'b0;
    bit new_addr = 1'b0;
    logic [31:0] a;
    @(posedge clk); #1;
    a = rnd_addr();
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = a;
    for (int c = 0; c < 4 * (LAT1 + 3); c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (new_addr) begin a = rnd_addr(); bus1.cpu_addr = a; new_addr = 1'b0; end
      end
      @(negedge clk);
      total++;
      if ((bus1.mem_en & prev_en) !== 1'b0) begin
        bad++; $display("FAIL b2b_adjacent_en c=%0d got=1 want=0", c);
      end
      prev_en = bus1.mem_en;
      if (bus1.cpu_stall === 1'b1) hi++;
      else begin
        total++;
        if (hi !== LAT1 + 2) begin
          bad++; $display("FAIL b2b_stall_len got=%0d want=%0d", hi, LAT1 + 2);
        end
        total++;
        if (bus1.cpu_rdata !== (a ^ 32'h5A5A_0000)) begin
          bad++; $display("FAIL b2b_rdata got=%h want=%h", bus1.cpu_rdata, a ^ 32'h5A5A_0000);
        end
        hi = 0;
        n_done++;
        new_addr = 1'b1;
      end
    end
    total++;
    if (n_done !== 4) begin
      bad++; $display("FAIL b2b_count got=%0d want=4", n_done);
    end
    @(posedge clk); #1;
    bus1.cpu_req = 1'b0;
  endtask

  // Random requesters; expectations come from cycle arithmetic: an access issued
  // in cycle t strobes mem_en at t+1, completes at t+LAT+2, frees the port at t+LAT+3.
  task automatic test_random(input int ncyc);
    int issue = -100, done_at = -100, free_at = 0, cnt = 0;
    bit acc_dbg = 1'b0, acc_we = 1'b0, cpu_busy = 1'b0, dbg_wait = 1'b0;
    bit done_now, exp_stall, exp_rv, exp_busy, exp_en, exp_gnt;
    logic [31:0] acc_addr = '0, acc_wdata = '0;
    for (int now = 0; now < ncyc; now++) begin
      @(posedge clk); #1;
      if (!cpu_busy) begin
        bus.cpu_req = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          cpu_busy = 1'b1;
          bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom_range(0, 1));
          bus.cpu_addr = rnd_addr(); bus.cpu_wdata = $urandom();
        end
      end
      if (!dbg_wait) begin
        bus.dbg_req = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          dbg_wait = 1'b1;
          bus.dbg_req = 1'b1; bus.dbg_we = 1'($urandom_range(0, 1));
          bus.dbg_addr = rnd_addr(); bus.dbg_wdata = $urandom();
        end
      end
      done_now  = (now == done_at);
      exp_stall = bus.cpu_req && !(done_now && !acc_dbg);
      exp_rv    = done_now && acc_dbg;
      exp_busy  = (now > issue) && (now < free_at);
      exp_en    = (now == issue + 1);
      exp_gnt   = 1'b0;
      if (now >= free_at && (bus.cpu_req || bus.dbg_req)) begin
        acc_dbg = bus.dbg_req && (!bus.cpu_req || cnt == MAXW);
        if (bus.cpu_req && bus.dbg_req) cnt = acc_dbg ? 0 : cnt + 1;
        else if (acc_dbg) cnt = 0;
        acc_we    = acc_dbg ? bus.dbg_we : bus.cpu_we;
        acc_addr  = acc_dbg ? bus.dbg_addr : bus.cpu_addr;
        acc_wdata = acc_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        if (acc_we) ref_mem[acc_addr[7:2]] = acc_wdata;
        else if (acc_dbg) m_dbg = ref_mem[acc_addr[7:2]];
        else m_cpu = ref_mem[acc_addr[7:2]];
        issue   = now;
        done_at = now + LAT + 2;
        free_at = now + LAT + 3;
        exp_gnt = acc_dbg;
      end
      @(negedge clk);
      total++;
      if (st0() !== {exp_stall, exp_gnt, exp_rv, exp_busy, exp_en}) begin
        bad++; $display("FAIL rand_status t=%0d got=%b want=%b", now, st0(),
                        {exp_stall, exp_gnt, exp_rv, exp_busy, exp_en});
      end
      if (exp_en) begin
        total++;
        if (bus.mem_we !== acc_we || bus.mem_addr !== acc_addr || (acc_we && bus.mem_wdata !== acc_wdata)) begin
          bad++; $display("FAIL rand_membus t=%0d got we=%b a=%h d=%h want we=%b a=%h d=%h", now,
                          bus.mem_we, bus.mem_addr, bus.mem_wdata, acc_we, acc_addr, acc_wdata);
        end
      end
      if (done_now) begin
        total++;
        if (bus.cpu_rdata !== m_cpu || bus.dbg_rdata !== m_dbg) begin
          bad++; $display("FAIL rand_rdata t=%0d got=%h/%h want=%h/%h", now,
                          bus.cpu_rdata, bus.dbg_rdata, m_cpu, m_dbg);
        end
      end
      if (cpu_busy && !exp_stall) cpu_busy = 1'b0;
      if (dbg_wait && exp_gnt) dbg_wait = 1'b0;
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    for (int i = 0; i < 20 && bus.busy !== 1'b0; i++) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL rand_drain got busy=%b want=0", bus.busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.dbg_req = 1'b0; bus1.dbg_we = 1'b0; bus1.dbg_addr = '0; bus1.dbg_wdata = '0;
    m_cpu = '0;
    m_dbg = '0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dbg_read();
    test_contention();
    test_reset_midaccess();
    test_back_to_back();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
